// File: rtl/seg_scan_ctrl_if.sv
// Display-scan interface: value producer side (en/load/value) and encoder/driver side
// (data/digit_sel/blank/frame_done). master = producer/testbench, slave = seg_scan_ctrl.
interface seg_scan_ctrl_if #(
    parameter int unsigned DIGITS = 4
);
    logic                  en;
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [3:0]            data;
    logic [DIGITS-1:0]     digit_sel;
    logic                  blank;
    logic                  frame_done;

    modport master (
        output en, load, value,
        input  data, digit_sel, blank, frame_done
    );

    modport slave (
        input  en, load, value,
        output data, digit_sel, blank, frame_done
    );
endinterface

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller: steps one shared BCD encoder across DIGITS
// positions with optional blanking gaps, and double-buffers the displayed value so that
// updates land only on frame boundaries.
// Optional feature macro: LEADING_ZERO_BLANK_EN (suppress leading zero digits).
module seg_scan_ctrl #(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DWELL  = 16,
    parameter int unsigned BLANK  = 2
) (
    input logic            clk,
    input logic            rst,
    seg_scan_ctrl_if.slave bus
);

    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntMax = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
    localparam int unsigned VW     = 4 * DIGITS;

    localparam logic [IdxW-1:0] LastIdx  = IdxW'(DIGITS - 1);
    localparam logic [CntW-1:0] DwellEnd = CntW'(DWELL - 1);
    localparam logic [CntW-1:0] BlankEnd = CntW'((BLANK > 0) ? BLANK - 1 : 0);

    typedef enum logic [1:0] {StIdle, StShow, StBlank} state_e;

    // The frame ends on the last cycle of digit DIGITS-1's final phase.
    localparam state_e          FinalSt  = (BLANK > 0) ? StBlank : StShow;
    localparam logic [CntW-1:0] FinalCnt = (BLANK > 0) ? BlankEnd : DwellEnd;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              phase_end;

    logic [VW-1:0]     shadow_q, shadow_d;
    logic [VW-1:0]     active_q, active_d;
    logic              pending_q, pending_d;
    logic              commit;

    logic [3:0]        data_q, data_d;
    logic [DIGITS-1:0] sel_q, sel_d;
    logic              blank_q, blank_d;
    logic              fd_q, fd_d;
    logic [3:0]        nib;
`ifdef LEADING_ZERO_BLANK_EN
    logic              upper_nz;
`endif

    // Scan sequencer: dwell/blank counting and digit stepping; en low forces idle.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        phase_end = 1'b0;
        unique case (state_q)
            StIdle: begin
                state_d = StShow;
                idx_d   = '0;
                cnt_d   = '0;
            end
            StShow: begin
                if (cnt_q == DwellEnd) begin
                    cnt_d = '0;
                    if (BLANK > 0) begin
                        state_d = StBlank;
                    end else begin
                        phase_end = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBlank: begin
                if (cnt_q == BlankEnd) begin
                    cnt_d     = '0;
                    state_d   = StShow;
                    phase_end = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        if (phase_end) begin
            idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;
        end
        if (!bus.en) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end
    end

    // Double buffer: loads go to shadow; shadow moves to active at a frame boundary or
    // when leaving idle, so the next SHOW(0) already uses the committed value.
    always_comb begin
        commit    = bus.en && pending_q && ((state_q == StIdle) || fd_q);
        active_d  = commit ? shadow_q : active_q;
        shadow_d  = bus.load ? bus.value : shadow_q;
        pending_d = bus.load ? 1'b1 : (commit ? 1'b0 : pending_q);
    end

    // Registered outputs are computed from the next state so they align with it.
    always_comb begin
        nib     = 4'hF;
        sel_d   = '0;
        data_d  = 4'hF;
        blank_d = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IdxW'(i)) begin
                nib = active_d[4*i +: 4];
            end
        end
`ifdef LEADING_ZERO_BLANK_EN
        // Suppress when this nibble and all higher ones are zero; digit 0 always shows.
        upper_nz = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IdxW'(i) >= idx_d && active_d[4*i +: 4] != 4'h0) begin
                upper_nz = 1'b1;
            end
        end
        if (idx_d != '0 && !upper_nz) begin
            nib = 4'hF;
        end
`endif
        if (state_d == StShow) begin
            sel_d   = DIGITS'(1) << idx_d;
            data_d  = nib;
            blank_d = 1'b0;
        end
        fd_d = (state_d == FinalSt) && (idx_d == LastIdx) && (cnt_d == FinalCnt);
    end

    // State, buffers and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            cnt_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            data_q    <= 4'hF;
            sel_q     <= '0;
            blank_q   <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            data_q    <= data_d;
            sel_q     <= sel_d;
            blank_q   <= blank_d;
            fd_q      <= fd_d;
        end
    end

    assign bus.data       = data_q;
    assign bus.digit_sel  = sel_q;
    assign bus.blank      = blank_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: main instance DIGITS=4/DWELL=4/BLANK=1 and a fast
// instance DWELL=1/BLANK=0. Leading-zero expectations follow LEADING_ZERO_BLANK_EN.
module tb_seg_scan_ctrl;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl_if #(.DIGITS(4)) bus ();
    seg_scan_ctrl_if #(.DIGITS(4)) bus_fast ();

    seg_scan_ctrl #(.DIGITS(4), .DWELL(4), .BLANK(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seg_scan_ctrl #(.DIGITS(4), .DWELL(1), .BLANK(0)) dut_fast (
        .clk (clk),
        .rst (rst),
        .bus (bus_fast)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] es, input logic [3:0] ed,
                              input logic eb, input logic efd);
        chk({tag, " sel"}, bus.digit_sel, es);
        chk({tag, " data"}, bus.data, ed);
        chk({tag, " blank"}, bus.blank, eb);
        chk({tag, " frame_done"}, bus.frame_done, efd);
    endtask

    // Walks ncyc cycles of a 20-cycle frame from position 0, expecting exp_nib on screen;
    // optionally pulses load at two positions.
    task automatic run_frame(input string name, input logic [15:0] exp_nib, input int ncyc,
                             input int la1, input logic [15:0] lv1,
                             input int la2, input logic [15:0] lv2);
        int         d;
        int         ph;
        logic [3:0] es;
        logic [3:0] ed;
        logic       eb;
        for (int p = 0; p < ncyc; p++) begin
            d  = p / 5;
            ph = p % 5;
            if (ph < 4) begin
                es = 4'b0001 << d;
                ed = exp_nib[4*d +: 4];
                eb = 1'b0;
            end else begin
                es = 4'b0000;
                ed = 4'hF;
                eb = 1'b1;
            end
            check_outs($sformatf("%s p%0d", name, p), es, ed, eb, p == 19);
            bus.load = 1'b0;
            if (p == la1) begin
                bus.load  = 1'b1;
                bus.value = lv1;
            end
            if (p == la2) begin
                bus.load  = 1'b1;
                bus.value = lv2;
            end
            step();
        end
        bus.load = 1'b0;
    endtask

    initial begin
        logic [15:0] exp_0045;
        logic [15:0] exp_0000;
        logic [15:0] fast_val;
`ifdef LEADING_ZERO_BLANK_EN
        exp_0045 = 16'hFF45;
        exp_0000 = 16'hFFF0;
`else
        exp_0045 = 16'h0045;
        exp_0000 = 16'h0000;
`endif
        fast_val = 16'h4321;

        rst            = 1'b1;
        bus.en         = 1'b1;
        bus.load       = 1'b0;
        bus.value      = 16'h0;
        bus_fast.en    = 1'b0;
        bus_fast.load  = 1'b0;
        bus_fast.value = 16'h0;
        repeat (3) step();
        check_outs("reset", 4'b0000, 4'hF, 1'b1, 1'b0);
        chk("fast reset sel", bus_fast.digit_sel, 4'b0000);

        // Preload while idle, then enable: commit happens on IDLE->SHOW.
        rst       = 1'b0;
        bus.en    = 1'b0;
        bus.load  = 1'b1;
        bus.value = 16'h1234;
        step();
        check_outs("idle after load", 4'b0000, 4'hF, 1'b1, 1'b0);
        bus.load = 1'b0;
        bus.en   = 1'b1;
        step();

        // Two mid-frame loads: last one wins, shown next frame.
        run_frame("f1_1234", 16'h1234, 20, 2, 16'h4321, 7, 16'h5678);
        // Load mid-frame then again on the frame_done cycle (deferred one frame).
        run_frame("f2_5678", 16'h5678, 20, 5, 16'h1111, 19, 16'h9999);
        run_frame("f3_1111", 16'h1111, 20, -1, 16'h0, -1, 16'h0);
        run_frame("f4_9999", 16'h9999, 20, -1, 16'h0, -1, 16'h0);

        // Abort while showing digit 2.
        run_frame("f5_part", 16'h9999, 13, -1, 16'h0, -1, 16'h0);
        bus.en = 1'b0;
        step();
        check_outs("abort idle", 4'b0000, 4'hF, 1'b1, 1'b0);
        bus.en = 1'b1;
        step();
        run_frame("f6_restart", 16'h9999, 20, 3, 16'h0045, -1, 16'h0);
        run_frame("f7_0045", exp_0045, 20, 3, 16'h0000, -1, 16'h0);
        run_frame("f8_0000", exp_0000, 20, 3, 16'h1005, -1, 16'h0);
        run_frame("f9_1005", 16'h1005, 20, -1, 16'h0, -1, 16'h0);

        // Fast instance: one cycle per digit, no blanking.
        bus.en         = 1'b0;
        bus_fast.load  = 1'b1;
        bus_fast.value = 16'h4321;
        step();
        bus_fast.load = 1'b0;
        bus_fast.en   = 1'b1;
        step();
        for (int p = 0; p < 8; p++) begin
            chk($sformatf("fast p%0d sel", p), bus_fast.digit_sel, 4'b0001 << (p % 4));
            chk($sformatf("fast p%0d data", p), bus_fast.data, fast_val[4*(p%4) +: 4]);
            chk($sformatf("fast p%0d blank", p), bus_fast.blank, 1'b0);
            chk($sformatf("fast p%0d frame_done", p), bus_fast.frame_done, (p % 4) == 3);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
